// File: rtl/btn_debouncer.sv
// Button/switch debouncer: two-flop synchronizer, stability-count FSM,
// registered debounced level, one-cycle rise/fall pulses and a press toggle.
module btn_debouncer #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_WIDTH     = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_rise,
   output logic btn_fall,
   output logic toggle_q
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      LOW       = 2'd0,
      RISE_WAIT = 2'd1,
      HIGH      = 2'd2,
      FALL_WAIT = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 s1_q, s2_q;
   logic                 level_q, level_d;
   logic                 rise_q, rise_d;
   logic                 fall_q, fall_d;
   logic                 tog_q, tog_d;

   // Next-state: a new value must hold STABLE_CYCLES synchronized cycles; any
   // single disagreement drops back to the stable state with the count cleared.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      tog_d   = tog_q;
      unique case (state_q)
         LOW: begin
            level_d = 1'b0;
            if (s2_q) begin
               state_d = RISE_WAIT;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         RISE_WAIT: begin
            level_d = 1'b0;
            if (!s2_q) begin
               state_d = LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HIGH;
               level_d = 1'b1;
               rise_d  = 1'b1;
               tog_d   = ~tog_q;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         HIGH: begin
            level_d = 1'b1;
            if (!s2_q) begin
               state_d = FALL_WAIT;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         FALL_WAIT: begin
            level_d = 1'b1;
            if (s2_q) begin
               state_d = HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = LOW;
               level_d = 1'b0;
               fall_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = LOW;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= LOW;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         tog_q   <= 1'b0;
      end else begin
         s1_q    <= btn_in;
         s2_q    <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         tog_q   <= tog_d;
      end
   end

   assign btn_level = level_q;
   assign btn_rise  = rise_q;
   assign btn_fall  = fall_q;
   assign toggle_q  = tog_q;

endmodule

// File: doc/btn_debouncer.md
# btn_debouncer

Conditions a raw, bouncing push-button or slide-switch input from the lab board into a clean, clock-synchronous level plus single-cycle edge pulses and a press-toggled bit. It sits directly upstream of the lab's combinational datapath blocks and drives their single-bit inputs on hardware: the inverter's `A`, gate inputs, and similar. Those blocks see a stable value that changes at most once per debounce window.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive synchronized cycles the input must hold a new value before it is accepted. Must be ≥ 2.
- `CNT_WIDTH`, default 3: stability counter width. Must satisfy 2^CNT_WIDTH > STABLE_CYCLES−1.

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset. Asserting it clears all state immediately; release is sampled synchronously.
- `btn_in`  input  1  raw asynchronous button or switch level; may bounce.
- `btn_level`  output  1  debounced level, registered.
- `btn_rise`  output  1  one-cycle pulse when `btn_level` goes 0→1, registered.
- `btn_fall`  output  1  one-cycle pulse when `btn_level` goes 1→0, registered.
- `toggle_q`  output  1  inverts on every accepted rising edge, registered.

## Operation
- Synchronizer: two flops, `s1 <= btn_in`, then `s2 <= s1`. Only `s2` feeds the rest of the logic.
- The FSM has four states:
  - LOW: `btn_level`=0. If `s2`=1, go to RISE_WAIT with `cnt` = 1. Otherwise stay, with `cnt` = 0.
  - RISE_WAIT: `btn_level`=0.
    - `s2`=0 (bounce): return to LOW, `cnt` = 0.
    - `s2`=1 and `cnt` = STABLE_CYCLES−1: go to HIGH, set `btn_level`=1, pulse `btn_rise`, flip `toggle_q`, set `cnt` = 0.
    - Otherwise: `cnt` +1.
  - HIGH: mirror of LOW. Triggers on `s2`=0 and goes to FALL_WAIT.
  - FALL_WAIT: mirror of RISE_WAIT. On acceptance, go to LOW, set `btn_level`=0, pulse `btn_fall`.
- A single cycle of disagreement in a WAIT state returns the FSM to the stable state and restarts the count from scratch. Counts never accumulate across bounces.
- `cnt` never exceeds STABLE_CYCLES−1 and never wraps.
- `btn_rise` and `btn_fall` are never asserted in the same cycle. Each lasts exactly one cycle.
- An illegal or unused state encoding recovers to LOW on the next edge with all outputs 0 except `toggle_q`, which holds.
- Reset: `s1`, `s2`, `cnt`, `btn_level`, `btn_rise`, `btn_fall`, and `toggle_q` are all 0, and the state is LOW.
- Reset mid-operation: a WAIT in progress is abandoned and no pulse is produced. If `btn_in` is held high through reset release, a fresh rise is accepted with normal latency measured from the first edge after release.

## Timing
- Edge numbering: edge 1 is the first rising `clk` edge at which `btn_in` is sampled at its new value.
- `s2` shows the new value after edge 2. The FSM enters WAIT at edge 3 with `cnt`=1.
- Acceptance occurs at edge 2+STABLE_CYCLES, assuming no bounce. `btn_level` changes and the pulse asserts at that edge. The pulse deasserts at the next edge.
- Latency from input change to output change: 2+STABLE_CYCLES cycles. This is 6 at default.
- Minimum glitch-free hold: STABLE_CYCLES synchronized cycles. A pulse on `btn_in` shorter than that produces no output change.
- Outputs are purely registered. There is no combinational path from `btn_in` to any output.
- Downstream combinational blocks may sample `btn_level` one cycle after its change.

## Test plan
All scenarios use STABLE_CYCLES=4.
- Reset: hold `rst_n`=0 with `btn_in`=1 for 3 cycles. Every output must read 0 throughout. Release at edge 0. `btn_level` rises at edge 6, and `btn_rise`=1 during cycle 6 only.
- Clean press: set `btn_in` 0→1 before edge 1 and hold it. `btn_level`=1 from edge 6. `btn_rise` pulses for one cycle. `toggle_q` goes 0→1. `btn_fall` stays 0.
- Bounce: `btn_in` 1,0,1,0 on alternating edges 1–4, then steady 1. There must be no output change before the steady run completes. `btn_level` rises at edge 4+6=10 and `btn_rise` pulses once.
- Short glitch: `btn_in`=1 for 3 edges, then back to 0. `btn_level`, `btn_rise`, and `toggle_q` all remain 0.
- Release and toggle: press, release, press, each phase held 10 cycles. The sequence is `btn_rise`, then `btn_fall` 6 edges after the release, then `btn_rise` again. `toggle_q` reads 1, then 0 after the second press. Each pulse lasts exactly one cycle.
- Reset mid-wait: drive `btn_in`=1, then assert `rst_n`=0 at edge 4 while in RISE_WAIT. All outputs must clear immediately with no `btn_rise`. Release `rst_n` and keep `btn_in`=1. `btn_rise` asserts 6 edges after release.
